column_scheduler: RTL and testbench
===================================

# column_scheduler

Game-level controller sitting above the per-column falling-letter state machines. It owns the shared drop time base, decides when and where new letters spawn, and arbitrates each keystroke to exactly one matching column. It also keeps score and level, scales drop speed with level, and aggregates bottom-reached events into a single game-over.

## Interface
- NUM_COLS, 4, number of column machines controlled
- BASE_TICK, 50000000, drop period in clocks at level 0
- TICK_STEP, 5000000, period reduction per level
- MIN_TICK, 10000000, floor on drop period
- SPAWN_GAP, 3, drop ticks between spawns
- POINTS_PER_LEVEL, 8, score points per level step
- clock  in  1  system clock; all logic on posedge
- reset_signal  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse: begin or restart a game
- key_valid  in  1  one-cycle strobe: key_code valid
- key_code  in  8  ASCII of pressed key
- col_busy  in  NUM_COLS  column i holds a falling letter
- col_letter  in  8*NUM_COLS  letter of column i, bits [8i+7:8i]
- col_ypos  in  5*NUM_COLS  row of column i, bits [5i+4:5i]
- col_bottom  in  NUM_COLS  column i reached bottom row
- col_spawn  out  NUM_COLS  one-hot pulse: load new letter into column i
- col_hit  out  NUM_COLS  one-hot pulse: column i letter typed correctly
- drop_tick  out  1  one-cycle pulse: all busy columns move down one row
- score  out  8  correct hits, saturating
- level  out  3  current speed level
- game_over  out  1  high in OVER
- sched_state  out  2  IDLE=0, RUN=1, OVER=2

## Operation
- Reset (reset_signal=0 at a clock edge): state IDLE; every output 0; tick counter, spawn counter, and round-robin pointer cleared. Reset mid-game aborts immediately.
- IDLE: no ticks or spawns; keys ignored. start -> RUN; score, level, and counters cleared; immediate col_spawn to column 0 on the first RUN cycle.
- RUN:
  - tick_cnt counts 0..period-1. drop_tick pulses on the cycle tick_cnt==period-1, then tick_cnt wraps to 0.
  - period = max(BASE_TICK - level*TICK_STEP, MIN_TICK). Level changes take effect at the next wrap.
  - Spawn: every SPAWN_GAP drop ticks, pulse col_spawn for the first non-busy column at or after rr_ptr, modulo NUM_COLS. rr_ptr then moves to that index+1. If all columns are busy, the spawn is skipped and the gap counter restarts.
  - Key arbitration: on key_valid, candidates are busy columns with col_letter==key_code. The winner is the candidate with the largest ypos; ties go to the lowest index. col_hit pulses one-hot on the winner and score increments, saturating at 255. No candidate means no hit and no penalty.
  - level = min(score / POINTS_PER_LEVEL, 7).
  - Any col_bottom bit set -> OVER.
- OVER: game_over=1. Ticks, spawns, and hits are suppressed; score and level hold. start -> RUN as from IDLE.
- Simultaneous events:
  - col_bottom and a matching key in the same cycle: bottom wins; no hit, no score.
  - Spawn and hit in the same cycle: the hit column is excluded as a spawn target.
  - drop_tick and hit in the same cycle: both issued.
  - start while in RUN is ignored.

## Timing
- col_hit and score update are registered: 1 cycle after key_valid.
- col_spawn, drop_tick, and col_hit are each exactly one cycle wide.
- game_over and sched_state update 1 cycle after col_bottom.
- First col_spawn is 1 cycle after start.
- First drop_tick occurs period cycles after entering RUN.

## Structure
- Shared package flippy_pkg holds:
  - state encoding (IDLE/RUN/OVER)
  - LETTER_W=8, YPOS_W=5, BOTTOM_ROW=21
  - MAX_LEVEL=7
- Sub-module drop_timer: loadable period counter producing the drop_tick pulse, with enable and clear.
- Arbitration, spawn selection, and score live in column_scheduler.

## Test plan
Parameters: NUM_COLS=4, BASE_TICK=10, TICK_STEP=2, MIN_TICK=4, SPAWN_GAP=2, POINTS_PER_LEVEL=2.
- Reset low then start -> col_spawn=0001 next cycle; drop_tick every 10 cycles; col_spawn=0010 after the 2nd tick.
- Columns 1 and 3 busy with 'A', ypos 4 and 7; key 'A' -> col_hit=1000 one cycle later, score=1. Repeat with equal ypos -> col_hit=0010.
- Score reaches 2 -> level=1 and period becomes 8 from the next wrap. Score 255 plus a hit -> stays 255. Score 16 -> level 7, period clamps at 4.
- col_bottom=0100 in the same cycle as a matching key -> no col_hit; game_over=1 next cycle; ticks stop; start -> RUN, score=0.
- All columns busy at a spawn point -> no col_spawn; gap restarts. Hit on column 2 coinciding with a spawn -> spawn target is not column 2.
- reset_signal low mid-RUN -> all outputs 0 at the next edge, sched_state=IDLE.

Source files
------------

// File: rtl/flippy_pkg.sv
// ----------------------------------------------------------------------------
// flippy_pkg
// Shared definitions for the falling-letter game controller.
//   - sched_state_e : scheduler state encoding (IDLE=0, RUN=1, OVER=2)
//   - LETTER_W / YPOS_W : width of a column's letter and row fields
//   - BOTTOM_ROW : last row a column machine can occupy
//   - MAX_LEVEL : highest speed level
//   - level_period() : drop period for a given level, floored at MIN_TICK
//   - score_level()  : level reached for a given score, capped at MAX_LEVEL
// ----------------------------------------------------------------------------
package flippy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } sched_state_e;

    localparam int LETTER_W   = 8;
    localparam int YPOS_W     = 5;
    localparam int BOTTOM_ROW = 21;
    localparam int MAX_LEVEL  = 7;
    localparam int SCORE_W    = 8;
    localparam int LEVEL_W    = 3;
    localparam int TICK_W     = 32;

    // Period shrinks linearly with level but never drops below min_tick.
    function automatic logic [TICK_W-1:0] level_period(
        input int                 base_tick,
        input int                 tick_step,
        input int                 min_tick,
        input logic [LEVEL_W-1:0] lvl
    );
        int p;
        p = base_tick - int'(lvl) * tick_step;
        if (p < min_tick) begin
            p = min_tick;
        end
        return TICK_W'(p);
    endfunction

    function automatic logic [LEVEL_W-1:0] score_level(
        input logic [SCORE_W-1:0] pts,
        input int                 points_per_level
    );
        int l;
        l = int'(pts) / points_per_level;
        if (l > MAX_LEVEL) begin
            l = MAX_LEVEL;
        end
        return LEVEL_W'(l);
    endfunction

endpackage

// File: rtl/column_scheduler_if.sv
// ----------------------------------------------------------------------------
// column_scheduler_if
// Bundle between the scheduler and the per-column letter machines.
//   key_valid / key_code : keystroke strobe and ASCII code
//   col_busy/letter/ypos/bottom : per-column status, column i in slice i
//   col_spawn / col_hit  : one-hot command pulses to the columns
//   drop_tick            : shared one-cycle "move down one row" pulse
// Modports: slave = scheduler side, master = column/keyboard side.
// ----------------------------------------------------------------------------
interface column_scheduler_if #(
    parameter int NUM_COLS = 4
);
    import flippy_pkg::*;

    logic                         key_valid;
    logic [LETTER_W-1:0]          key_code;
    logic [NUM_COLS-1:0]          col_busy;
    logic [LETTER_W*NUM_COLS-1:0] col_letter;
    logic [YPOS_W*NUM_COLS-1:0]   col_ypos;
    logic [NUM_COLS-1:0]          col_bottom;
    logic [NUM_COLS-1:0]          col_spawn;
    logic [NUM_COLS-1:0]          col_hit;
    logic                         drop_tick;

    modport slave (
        input  key_valid, key_code, col_busy, col_letter, col_ypos, col_bottom,
        output col_spawn, col_hit, drop_tick
    );

    modport master (
        output key_valid, key_code, col_busy, col_letter, col_ypos, col_bottom,
        input  col_spawn, col_hit, drop_tick
    );

endinterface

// File: rtl/drop_timer.sv
// ----------------------------------------------------------------------------
// drop_timer
// Loadable period counter generating the shared drop tick.
//   clock, reset_signal : clock and synchronous active-low reset
//   en     : count while high; counter holds when low
//   clr    : restart counting from zero and load a fresh period
//   period : period to adopt at the next clear or wrap
//   tick   : registered one-cycle pulse, issued on the wrap cycle
// The period is only sampled at clear/wrap so a level change never cuts a
// drop interval short.
// ----------------------------------------------------------------------------
module drop_timer
    import flippy_pkg::*;
(
    input  logic              clock,
    input  logic              reset_signal,
    input  logic              en,
    input  logic              clr,
    input  logic [TICK_W-1:0] period,
    output logic              tick
);

    localparam logic [TICK_W-1:0] ONE = TICK_W'(1);

    logic [TICK_W-1:0] cnt_q, cnt_d;
    logic [TICK_W-1:0] period_q, period_d;
    logic              tick_q, tick_d;

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        tick_d   = 1'b0;
        if (clr) begin
            cnt_d    = '0;
            period_d = period;
        end else if (en) begin
            if (cnt_q >= period_q - ONE) begin
                cnt_d    = '0;
                period_d = period;
                tick_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            cnt_q    <= '0;
            period_q <= period;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            tick_q   <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/column_scheduler.sv
// ----------------------------------------------------------------------------
// column_scheduler
// Game-level controller above the per-column falling-letter machines.
//   clock, reset_signal : clock and synchronous active-low reset
//   start       : pulse to begin/restart a game (ignored while running)
//   bus         : column/keyboard bundle (slave side)
//   score       : correct hits, saturating at 255
//   level       : min(score / POINTS_PER_LEVEL, MAX_LEVEL)
//   game_over   : high while in OVER
//   sched_state : IDLE=0, RUN=1, OVER=2
// All outputs are registered. Arbitration, spawn selection and scoring are
// evaluated in the same cycle so a hit column can be excluded from a spawn.
// ----------------------------------------------------------------------------
module column_scheduler
    import flippy_pkg::*;
#(
    parameter int NUM_COLS         = 4,
    parameter int BASE_TICK        = 50000000,
    parameter int TICK_STEP        = 5000000,
    parameter int MIN_TICK         = 10000000,
    parameter int SPAWN_GAP        = 3,
    parameter int POINTS_PER_LEVEL = 8
) (
    input  logic               clock,
    input  logic               reset_signal,
    input  logic               start,
    column_scheduler_if.slave  bus,
    output logic [SCORE_W-1:0] score,
    output logic [LEVEL_W-1:0] level,
    output logic               game_over,
    output logic [1:0]         sched_state
);

    localparam int IDX_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
    localparam int GAP_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

    function automatic logic [IDX_W-1:0] wrap_add(
        input logic [IDX_W-1:0] base,
        input int               off
    );
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_COLS) begin
            sum = sum - NUM_COLS;
        end
        return IDX_W'(sum);
    endfunction

    function automatic logic [NUM_COLS-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_COLS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sched_state_e        state_q, state_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [LEVEL_W-1:0]  level_q, level_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [NUM_COLS-1:0] spawn_q, spawn_d;
    logic [NUM_COLS-1:0] hit_q, hit_d;
    logic                game_over_q, game_over_d;

    logic                timer_en;
    logic                timer_clr;
    logic [TICK_W-1:0]   timer_period;
    logic                drop_tick_w;

    // ------------------------------------------------------------------
    // Per-column unpacking and key match
    // ------------------------------------------------------------------
    logic [YPOS_W-1:0]   ypos [NUM_COLS];
    logic [NUM_COLS-1:0] match;

    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
        assign ypos[gi]  = bus.col_ypos[gi*YPOS_W +: YPOS_W];
        assign match[gi] = bus.col_busy[gi] &&
                           (bus.col_letter[gi*LETTER_W +: LETTER_W] == bus.key_code);
    end

    // ------------------------------------------------------------------
    // Key arbitration: lowest column closest to the bottom wins. The strict
    // greater-than keeps the lower index on equal rows.
    // ------------------------------------------------------------------
    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic [YPOS_W-1:0] win_y;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_y     = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (match[i] && (!win_found || ypos[i] > win_y)) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_y     = ypos[i];
            end
        end
    end

    logic                key_hit;
    logic [NUM_COLS-1:0] hit_onehot;

    assign key_hit    = bus.key_valid && win_found;
    assign hit_onehot = key_hit ? to_onehot(win_idx) : '0;

    // ------------------------------------------------------------------
    // Spawn target: first free column at or after rr_q. Scanning offsets
    // from high to low lets the smallest offset overwrite the result.
    // ------------------------------------------------------------------
    logic [NUM_COLS-1:0] avail;
    logic                sp_found;
    logic [IDX_W-1:0]    sp_idx;
    logic [IDX_W-1:0]    probe_idx;

    assign avail = ~bus.col_busy & ~hit_onehot;

    always_comb begin
        sp_found  = 1'b0;
        sp_idx    = '0;
        probe_idx = '0;
        for (int k = NUM_COLS - 1; k >= 0; k--) begin
            probe_idx = wrap_add(rr_q, k);
            if (avail[probe_idx]) begin
                sp_found = 1'b1;
                sp_idx   = probe_idx;
            end
        end
    end

    // ------------------------------------------------------------------
    // Game control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        level_d   = level_q;
        gap_d     = gap_q;
        rr_d      = rr_q;
        spawn_d   = '0;
        hit_d     = '0;
        timer_en  = 1'b0;
        timer_clr = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d   = ST_RUN;
                    score_d   = '0;
                    level_d   = '0;
                    gap_d     = '0;
                    spawn_d   = to_onehot('0);
                    rr_d      = wrap_add('0, 1);
                    timer_clr = 1'b1;
                end
            end
            ST_RUN: begin
                // A bottom event pre-empts everything else in this cycle.
                if (|bus.col_bottom) begin
                    state_d = ST_OVER;
                end else begin
                    timer_en = 1'b1;
                    hit_d    = hit_onehot;
                    if (key_hit && (score_q != '1)) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                    level_d = score_level(score_d, POINTS_PER_LEVEL);
                    if (drop_tick_w) begin
                        if (gap_q == GAP_W'(SPAWN_GAP - 1)) begin
                            // Gap restarts whether or not a column was free.
                            gap_d = '0;
                            if (sp_found) begin
                                spawn_d = to_onehot(sp_idx);
                                rr_d    = wrap_add(sp_idx, 1);
                            end
                        end else begin
                            gap_d = gap_q + GAP_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        game_over_d = (state_d == ST_OVER);
    end

    // A fresh game always starts at the level-0 period, otherwise the
    // period tracks the current level and is adopted at the next wrap.
    assign timer_period = level_period(BASE_TICK, TICK_STEP, MIN_TICK,
                                       timer_clr ? LEVEL_W'(0) : level_q);

    drop_timer u_drop_timer (
        .clock        (clock),
        .reset_signal (reset_signal),
        .en           (timer_en),
        .clr          (timer_clr),
        .period       (timer_period),
        .tick         (drop_tick_w)
    );

    always_ff @(posedge clock) begin
        if (!reset_signal) begin
            state_q     <= ST_IDLE;
            score_q     <= '0;
            level_q     <= '0;
            gap_q       <= '0;
            rr_q        <= '0;
            spawn_q     <= '0;
            hit_q       <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            score_q     <= score_d;
            level_q     <= level_d;
            gap_q       <= gap_d;
            rr_q        <= rr_d;
            spawn_q     <= spawn_d;
            hit_q       <= hit_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.col_spawn = spawn_q;
    assign bus.col_hit   = hit_q;
    assign bus.drop_tick = drop_tick_w;
    assign score         = score_q;
    assign level         = level_q;
    assign game_over     = game_over_q;
    assign sched_state   = state_q;

endmodule

// File: tb/tb_column_scheduler.sv
`timescale 1ns/1ps
module tb_column_scheduler;

    localparam int NUM_COLS  = 4;
    localparam int BASE_TICK = 10;
    localparam int TICK_STEP = 2;
    localparam int MIN_TICK  = 4;
    localparam int SPAWN_GAP = 2;
    localparam int PPL       = 2;

    logic       clock = 1'b0;
    logic       reset_signal = 1'b0;
    logic       start = 1'b0;
    logic [7:0] score;
    logic [2:0] level;
    logic       game_over;
    logic [1:0] sched_state;

    column_scheduler_if #(.NUM_COLS(NUM_COLS)) bus ();

    column_scheduler #(
        .NUM_COLS         (NUM_COLS),
        .BASE_TICK        (BASE_TICK),
        .TICK_STEP        (TICK_STEP),
        .MIN_TICK         (MIN_TICK),
        .SPAWN_GAP        (SPAWN_GAP),
        .POINTS_PER_LEVEL (PPL)
    ) dut (
        .clock        (clock),
        .reset_signal (reset_signal),
        .start        (start),
        .bus          (bus),
        .score        (score),
        .level        (level),
        .game_over    (game_over),
        .sched_state  (sched_state)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: game rules in plain integers
    // state: 0 idle, 1 run, 2 over
    // ------------------------------------------------------------------
    int         m_state = 0, m_score = 0, m_level = 0;
    int         m_cnt = 0, m_period = BASE_TICK, m_gap = 0, m_rr = 0;
    logic [3:0] m_spawn = '0, m_hit = '0;
    logic       m_tick = 1'b0;

    function automatic int period_of(input int lvl);
        int p;
        p = BASE_TICK - lvl * TICK_STEP;
        return (p < MIN_TICK) ? MIN_TICK : p;
    endfunction

    task automatic model_step();
        logic [3:0] nxt_spawn;
        logic [3:0] nxt_hit;
        logic       nxt_tick;
        int         win, best, sp, c, y;
        nxt_spawn = '0;
        nxt_hit   = '0;
        nxt_tick  = 1'b0;
        if (!reset_signal) begin
            m_state = 0; m_score = 0; m_level = 0; m_cnt = 0; m_gap = 0; m_rr = 0;
            m_period = period_of(0);
        end else if (m_state != 1) begin
            if (start) begin
                m_state = 1; m_score = 0; m_level = 0; m_cnt = 0; m_gap = 0;
                m_period = period_of(0);
                nxt_spawn = 4'b0001;
                m_rr = 1;
            end
        end else if (bus.col_bottom != '0) begin
            m_state = 2;
        end else begin
            win = -1;
            best = -1;
            for (int i = 0; i < NUM_COLS; i++) begin
                y = int'(bus.col_ypos[5*i +: 5]);
                if (bus.col_busy[i] && bus.col_letter[8*i +: 8] == bus.key_code && y > best) begin
                    win = i;
                    best = y;
                end
            end
            if (bus.key_valid && win >= 0) begin
                nxt_hit[win] = 1'b1;
                if (m_score < 255) m_score++;
            end
            if (m_tick) begin
                m_gap++;
                if (m_gap == SPAWN_GAP) begin
                    m_gap = 0;
                    sp = -1;
                    for (int k = 0; k < NUM_COLS; k++) begin
                        c = (m_rr + k) % NUM_COLS;
                        if (sp < 0 && !bus.col_busy[c] && !nxt_hit[c]) sp = c;
                    end
                    if (sp >= 0) begin
                        nxt_spawn[sp] = 1'b1;
                        m_rr = (sp + 1) % NUM_COLS;
                    end
                end
            end
            if (m_cnt == m_period - 1) begin
                nxt_tick = 1'b1;
                m_cnt = 0;
                m_period = period_of(m_level);
            end else begin
                m_cnt++;
            end
            m_level = (m_score / PPL > 7) ? 7 : m_score / PPL;
        end
        m_spawn = nxt_spawn;
        m_hit   = nxt_hit;
        m_tick  = nxt_tick;
    endtask

    // One clock: predict, advance, compare every output.
    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        cyc++;
        check_eq("col_spawn", bus.col_spawn, m_spawn);
        check_eq("col_hit", bus.col_hit, m_hit);
        check_eq("drop_tick", bus.drop_tick, m_tick);
        check_eq("score", score, m_score);
        check_eq("level", level, m_level);
        check_eq("game_over", game_over, (m_state == 2));
        check_eq("sched_state", sched_state, m_state);
    endtask

    task automatic clear_inputs();
        start          = 1'b0;
        bus.key_valid  = 1'b0;
        bus.key_code   = '0;
        bus.col_busy   = '0;
        bus.col_letter = '0;
        bus.col_ypos   = '0;
        bus.col_bottom = '0;
    endtask

    int t_a, t_b, sp_c, n_cnt;
    logic [3:0] sp_v;
    logic found;

    initial begin
        clear_inputs();

        // Reset
        reset_signal = 1'b0;
        repeat (3) cycle();
        check_eq("rst_state", sched_state, 0);
        check_eq("rst_spawn", bus.col_spawn, 0);

        // Start, tick cadence and second spawn
        reset_signal = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_eq("first_spawn", bus.col_spawn, 4'b0001);
        t_a = -1; t_b = -1; sp_c = -1; sp_v = '0;
        for (int k = 1; k <= 22; k++) begin
            cycle();
            if (bus.drop_tick) begin
                if (t_a < 0) t_a = k;
                else if (t_b < 0) t_b = k;
            end
            if (bus.col_spawn != '0 && sp_c < 0) begin
                sp_c = k;
                sp_v = bus.col_spawn;
            end
        end
        check_eq("tick1_cycle", t_a, 10);
        check_eq("tick2_cycle", t_b, 20);
        check_eq("spawn2_cycle", sp_c, 21);
        check_eq("spawn2_val", sp_v, 4'b0010);
        $display("phase start: ticks at %0d,%0d spawn at %0d", t_a, t_b, sp_c);

        // Arbitration: deepest wins, then tie goes to lowest index
        bus.col_busy   = 4'b1010;
        bus.col_letter = {8'h41, 8'h00, 8'h41, 8'h00};
        bus.col_ypos   = {5'd7, 5'd0, 5'd4, 5'd0};
        bus.key_valid  = 1'b1;
        bus.key_code   = 8'h41;
        cycle();
        check_eq("arb_deep_hit", bus.col_hit, 4'b1000);
        check_eq("arb_deep_score", score, 1);
        bus.col_ypos = {5'd5, 5'd0, 5'd5, 5'd0};
        cycle();
        bus.key_valid = 1'b0;
        check_eq("arb_tie_hit", bus.col_hit, 4'b0010);
        check_eq("arb_tie_level", level, 1);

        // Level 1 period takes effect from the next wrap
        t_a = -1; t_b = -1;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (bus.drop_tick) begin
                if (t_a < 0) t_a = k;
                else if (t_b < 0) t_b = k;
            end
        end
        check_eq("lvl1_period", t_b - t_a, 8);
        $display("phase level1: tick interval %0d", t_b - t_a);

        // Bottom beats a matching key
        bus.col_busy   = 4'b0100;
        bus.col_letter = {8'h00, 8'h42, 8'h00, 8'h00};
        bus.col_bottom = 4'b0100;
        bus.key_valid  = 1'b1;
        bus.key_code   = 8'h42;
        cycle();
        clear_inputs();
        check_eq("bottom_no_hit", bus.col_hit, 0);
        check_eq("bottom_over", game_over, 1);
        check_eq("bottom_state", sched_state, 2);
        n_cnt = 0;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (bus.drop_tick) n_cnt++;
        end
        check_eq("over_ticks", n_cnt, 0);
        start = 1'b1;
        cycle();
        start = 1'b0;
        check_eq("restart_state", sched_state, 1);
        check_eq("restart_score", score, 0);

        // All busy at the spawn point: skipped, gap restarts
        sp_c = -1; sp_v = '0;
        for (int k = 1; k <= 45; k++) begin
            bus.col_busy = (k <= 30) ? 4'b1111 : 4'b0000;
            cycle();
            if (bus.col_spawn != '0 && sp_c < 0) begin
                sp_c = k;
                sp_v = bus.col_spawn;
            end
        end
        check_eq("skip_spawn_cycle", sp_c, 41);
        check_eq("skip_spawn_val", sp_v, 4'b0010);
        $display("phase allbusy: next spawn at %0d val %0h", sp_c, sp_v);

        // Hit on column 2 in the same cycle as a spawn
        bus.col_busy   = 4'b0100;
        bus.col_letter = {8'h00, 8'h43, 8'h00, 8'h00};
        bus.col_ypos   = {5'd0, 5'd3, 5'd0, 5'd0};
        found = 1'b0;
        for (int k = 0; k < 60 && !found; k++) begin
            if (m_tick && m_gap == SPAWN_GAP - 1) found = 1'b1;
            else cycle();
        end
        check_eq("coinc_found", found, 1);
        bus.key_valid = 1'b1;
        bus.key_code  = 8'h43;
        cycle();
        bus.key_valid = 1'b0;
        check_eq("coinc_hit", bus.col_hit, 4'b0100);
        check_eq("coinc_spawn_not2", bus.col_spawn[2], 0);
        check_eq("coinc_spawn_any", |bus.col_spawn, 1);

        // Reset mid-RUN
        reset_signal = 1'b0;
        cycle();
        reset_signal = 1'b1;
        check_eq("midrst_state", sched_state, 0);
        check_eq("midrst_score", score, 0);
        check_eq("midrst_over", game_over, 0);
        check_eq("midrst_outs", {bus.col_spawn, bus.col_hit, bus.drop_tick}, 0);

        // Score saturation and period clamp
        clear_inputs();
        start = 1'b1;
        cycle();
        start = 1'b0;
        bus.col_busy   = 4'b1111;
        bus.col_letter = {4{8'h41}};
        bus.key_valid  = 1'b1;
        bus.key_code   = 8'h41;
        for (int k = 0; k < 300; k++) begin
            bus.col_ypos = 20'($urandom);
            cycle();
        end
        check_eq("sat_score", score, 255);
        check_eq("sat_level", level, 7);
        t_a = -1; t_b = -1;
        for (int k = 0; k < 15; k++) begin
            cycle();
            if (bus.drop_tick) begin
                if (t_a < 0) t_a = k;
                else if (t_b < 0) t_b = k;
            end
        end
        check_eq("clamp_period", t_b - t_a, 4);
        $display("phase saturate: score %0d level %0d period %0d", score, level, t_b - t_a);

        // Randomized play against the model
        clear_inputs();
        for (int k = 0; k < 2500; k++) begin
            reset_signal = ($urandom_range(0, 399) != 0);
            start = (m_state != 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 49) == 0);
            bus.col_busy = 4'($urandom);
            for (int i = 0; i < NUM_COLS; i++) begin
                bus.col_letter[8*i +: 8] = 8'h41 + 8'($urandom_range(0, 2));
                bus.col_ypos[5*i +: 5]   = 5'($urandom_range(0, 7));
            end
            bus.key_valid  = ($urandom_range(0, 9) < 4);
            bus.key_code   = 8'h41 + 8'($urandom_range(0, 2));
            bus.col_bottom = ($urandom_range(0, 149) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            cycle();
        end
        $display("phase random: 2500 cycles");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
